rs485_xcvr: RTL
===============

# rs485_xcvr

Parametrised half-duplex RS485 transceiver that replaces the fixed 8N1 uart_tx/uart_rx pair in RS485 designs. It adds configurable data width, parity, stop bits and automatic driver-enable control with a trailing turnaround guard. The receiver is blanked while the local driver is on, so a node never receives its own frames. It sits between the line pins (rx, tx, re) and the application logic (for example, the LED/key controller).

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- UART_BPS, 9600, baud rate
- DATA_W, 8, data bits per frame, legal range 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits transmitted, 1 or 2
- TURN_BITS, 1, bit periods re stays high after the last stop bit, 0..3

- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- pi_data  in  DATA_W  byte to transmit
- pi_flag  in  1  one-cycle transmit request
- tx_ready  out  1  high when a request will be accepted
- rx  in  1  line receive data, asynchronous
- tx  out  1  line transmit data, idle high
- re  out  1  driver enable (high = transmit, receiver blanked)
- po_data  out  DATA_W  received data, LSB first on the line
- po_flag  out  1  one-cycle pulse, po_data/po_err valid
- po_err  out  1  framing or parity error for the current po_flag

## Operation
- Bit period: BAUD_CNT_MAX = CLK_FREQ/UART_BPS − 1, using integer division. Every bit lasts BAUD_CNT_MAX+1 cycles.
- TX state machine: IDLE → START → DATA (DATA_W bits, LSB first) → PARITY (only if PARITY≠0) → STOP (STOP_BITS periods) → GUARD (TURN_BITS periods; skipped if 0) → IDLE.
- Line levels per TX state:
  - IDLE: tx=1, re=0.
  - START: tx=0.
  - PARITY: odd parity makes the total count of ones in data+parity odd; even parity makes it even.
  - STOP and GUARD: tx=1, re=1.
- tx_ready=1 only in IDLE.
- A pi_flag while tx_ready=0 is dropped, with no queueing.
- pi_data is latched on acceptance and may change afterwards.
- RX input conditioning: rx passes through a 2-FF synchroniser, and a falling edge is detected on the synchronised signal.
- RX state machine: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- Each received bit is sampled at count BAUD_CNT_MAX/2 within its bit period.
- False start: if the start-bit sample is 1, return to IDLE with no po_flag.
- End of frame: at the first stop-bit sample, drive po_data and pulse po_flag.
- po_err=1 if the stop bit sampled 0 or the parity mismatched; po_flag still pulses.
- A second stop bit is not checked.
- po_data and po_err hold their values until the next po_flag.
- Echo blanking:
  - While re=1, the RX state machine is forced to IDLE and edge detection is masked.
  - After re falls, the synchronised rx must be seen high for at least one cycle before a falling edge is accepted.

## Timing
- Reset values: tx=1, re=0, tx_ready=1, po_data=0, po_flag=0, po_err=0. Both state machines reset to IDLE and all counters reset to 0.
- Reset mid-frame aborts immediately: tx returns to 1 and re to 0 asynchronously, and no po_flag is produced.
- Acceptance at cycle N (pi_flag=1, tx_ready=1):
  - Cycle N+1: re=1, tx=0, tx_ready=0.
- Total time with re high: (1 + DATA_W + (PARITY≠0) + STOP_BITS + TURN_BITS) × (BAUD_CNT_MAX+1) cycles. Then re=0 and tx_ready=1 in the same cycle.
- Back-to-back transmission:
  - A pi_flag in the first cycle tx_ready=1 is accepted, and re drops to 0 for exactly one cycle between the two frames.
  - The next start bit follows on the next cycle.
- RX latency: po_flag rises 1 cycle after the stop-bit mid-sample. The synchroniser adds 2 cycles from the line to the edge detector.
- Simultaneous events: a pi_flag accepted while RX is mid-frame raises re, and the incoming frame is aborted silently.

## Structure
- Package rs485_pkg holds:
  - the PAR_NONE/PAR_ODD/PAR_EVEN constants;
  - the TX and RX state encodings;
  - a function computing BAUD_CNT_MAX.
- Sub-module rs485_bit_timer, instantiated once for TX and once for RX:
  - behaviour: a baud counter with start/clear inputs and mid_pulse/end_pulse outputs;
  - parameter: BAUD_CNT_MAX.

## Test plan
Bench configuration: CLK_FREQ=1_000_000, UART_BPS=100_000, giving 10 cycles per bit.

- 8N1, TURN_BITS=1, send 0xA5:
  - tx reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles;
  - re is high for 110 cycles;
  - tx_ready returns 1 at cycle 111 after acceptance.
- DATA_W=7, PARITY=2, STOP_BITS=2, send 0x45 (three ones):
  - parity bit = 1;
  - re is high for (1+7+1+2+1)×10 = 120 cycles.
- RX, 8O1, line frame 0x3C with correct parity:
  - po_data=0x3C, po_err=0, single po_flag.
- RX error frames, 8O1:
  - same frame with parity flipped → po_err=1;
  - same frame with stop bit = 0 → po_err=1.
- RX false start: a 3-cycle low glitch on rx → no po_flag, RX back in IDLE.
- Blanking and mid-frame reset:
  - rx tied to tx during a transmit → no po_flag;
  - pi_flag while tx_ready=0 → dropped;
  - sys_rst_n low at cycle 40 of a frame → tx=1 and re=0 immediately, no residual output.

Source files
------------

// File: rtl/rs485_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs485_pkg
// Brief    : Shared constants, FSM encodings and baud helper for rs485_xcvr.
// Revision : 1.0 - initial release
// ============================================================================
package rs485_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_GUARD  = 3'd5
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return (clk_freq / uart_bps) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs485_xcvr_if.sv
`default_nettype none
// ============================================================================
// Module   : rs485_xcvr_if
// Brief    : Application handshake and line pins of the RS485 transceiver.
// Revision : 1.0 - initial release
// ============================================================================
interface rs485_xcvr_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pi_data;
    logic              pi_flag;
    logic              tx_ready;
    logic              rx;
    logic              tx;
    logic              re;
    logic [DATA_W-1:0] po_data;
    logic              po_flag;
    logic              po_err;

    modport master (
        output pi_data, pi_flag, rx,
        input  tx_ready, tx, re, po_data, po_flag, po_err
    );

    modport slave (
        input  pi_data, pi_flag, rx,
        output tx_ready, tx, re, po_data, po_flag, po_err
    );
endinterface
`default_nettype wire

// File: rtl/rs485_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : rs485_bit_timer
// Brief    : Free-running bit-period counter with mid-bit and end-of-bit pulses.
// Revision : 1.0 - initial release
// ============================================================================
module rs485_bit_timer #(
    parameter int BAUD_CNT_MAX = 5207
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic mid_pulse,
    output logic end_pulse
);
    localparam int c_CNT_W = (BAUD_CNT_MAX < 1) ? 1 : $clog2(BAUD_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BAUD_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_MID  = c_CNT_W'(BAUD_CNT_MAX / 2);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;

    // start wins over clear so a new frame can begin in the cycle the old one ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (r_run) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_ONE;
        end
    end

    assign mid_pulse = r_run && (r_cnt == c_MID);
    assign end_pulse = r_run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rs485_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : rs485_xcvr
// Brief    : Half-duplex RS485 UART with parity, driver-enable and echo blanking.
// Revision : 1.0 - initial release
// ============================================================================
module rs485_xcvr
    import rs485_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TURN_BITS = 1
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    rs485_xcvr_if.slave    bus
);
    localparam int         c_BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic [3:0] c_DATA_LAST    = 4'(DATA_W - 1);
    localparam logic [3:0] c_STOP_LAST    = 4'(STOP_BITS - 1);
    localparam logic [3:0] c_TURN_LAST    = 4'((TURN_BITS > 0) ? TURN_BITS - 1 : 0);
    localparam logic       c_ODD          = (PARITY == PAR_ODD);

    tx_state_t         r_tx_state;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par;
    logic [3:0]        r_tx_bit_cnt;
    logic              r_tx;
    logic              r_re;
    logic              r_tx_ready;

    rx_state_t         r_rx_state;
    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_d;
    logic              r_rx_armed;
    logic [DATA_W-1:0] r_rx_shift;
    logic [3:0]        r_rx_bit_cnt;
    logic              r_rx_par_err;
    logic [DATA_W-1:0] r_po_data;
    logic              r_po_flag;
    logic              r_po_err;

    logic w_tx_accept;
    logic w_tx_end;
    logic w_tx_mid_unused;
    logic w_rx_fall;
    logic w_rx_start;
    logic w_rx_mid;
    logic w_rx_end_unused;

    assign w_tx_accept = bus.pi_flag && (r_tx_state == TX_IDLE);
    // edges are ignored while driving and until the line has been seen idle again
    assign w_rx_fall   = r_rx_armed && r_rx_d && !r_rx_s2 && !r_re;
    assign w_rx_start  = w_rx_fall && (r_rx_state == RX_IDLE);

    rs485_bit_timer #(.BAUD_CNT_MAX(c_BAUD_CNT_MAX)) u_tx_timer (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .start     (w_tx_accept),
        .clear     (r_tx_state == TX_IDLE),
        .mid_pulse (w_tx_mid_unused),
        .end_pulse (w_tx_end)
    );

    rs485_bit_timer #(.BAUD_CNT_MAX(c_BAUD_CNT_MAX)) u_rx_timer (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .start     (w_rx_start),
        .clear     ((r_rx_state == RX_IDLE) || r_re),
        .mid_pulse (w_rx_mid),
        .end_pulse (w_rx_end_unused)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_state   <= TX_IDLE;
            r_tx_shift   <= '0;
            r_tx_par     <= 1'b0;
            r_tx_bit_cnt <= '0;
            r_tx         <= 1'b1;
            r_re         <= 1'b0;
            r_tx_ready   <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= bus.pi_data;
                        r_tx_par   <= (^bus.pi_data) ^ c_ODD;
                        r_tx       <= 1'b0;
                        r_re       <= 1'b1;
                        r_tx_ready <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_end) begin
                        r_tx_state   <= TX_DATA;
                        r_tx         <= r_tx_shift[0];
                        r_tx_shift   <= r_tx_shift >> 1;
                        r_tx_bit_cnt <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_tx_end) begin
                        if (r_tx_bit_cnt == c_DATA_LAST) begin
                            r_tx_bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_tx_state <= TX_PARITY;
                                r_tx       <= r_tx_par;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
                            r_tx         <= r_tx_shift[0];
                            r_tx_shift   <= r_tx_shift >> 1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_tx_end) begin
                        r_tx_state   <= TX_STOP;
                        r_tx         <= 1'b1;
                        r_tx_bit_cnt <= '0;
                    end
                end
                TX_STOP: begin
                    if (w_tx_end) begin
                        if (r_tx_bit_cnt == c_STOP_LAST) begin
                            r_tx_bit_cnt <= '0;
                            if (TURN_BITS > 0) begin
                                r_tx_state <= TX_GUARD;
                            end else begin
                                r_tx_state <= TX_IDLE;
                                r_re       <= 1'b0;
                                r_tx_ready <= 1'b1;
                            end
                        end else begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
                        end
                    end
                end
                TX_GUARD: begin
                    if (w_tx_end) begin
                        if (r_tx_bit_cnt == c_TURN_LAST) begin
                            r_tx_state <= TX_IDLE;
                            r_re       <= 1'b0;
                            r_tx_ready <= 1'b1;
                        end else begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx       <= 1'b1;
                    r_re       <= 1'b0;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_armed <= 1'b0;
        end else begin
            r_rx_s1    <= bus.rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_armed <= r_re ? 1'b0 : (r_rx_armed || r_rx_s2);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_shift   <= '0;
            r_rx_bit_cnt <= '0;
            r_rx_par_err <= 1'b0;
            r_po_data    <= '0;
            r_po_flag    <= 1'b0;
            r_po_err     <= 1'b0;
        end else begin
            r_po_flag <= 1'b0;
            if (r_re) begin
                r_rx_state <= RX_IDLE;
            end else begin
                case (r_rx_state)
                    RX_IDLE: begin
                        if (w_rx_fall) begin
                            r_rx_state   <= RX_START;
                            r_rx_par_err <= 1'b0;
                        end
                    end
                    RX_START: begin
                        if (w_rx_mid) begin
                            r_rx_state   <= r_rx_s2 ? RX_IDLE : RX_DATA;
                            r_rx_bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (w_rx_mid) begin
                            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
                            if (r_rx_bit_cnt == c_DATA_LAST) begin
                                r_rx_bit_cnt <= '0;
                                r_rx_state   <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                r_rx_bit_cnt <= r_rx_bit_cnt + 4'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (w_rx_mid) begin
                            r_rx_par_err <= ((^r_rx_shift) ^ r_rx_s2) != c_ODD;
                            r_rx_state   <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        // only the first stop bit is judged; a second one just looks idle
                        if (w_rx_mid) begin
                            r_po_data  <= r_rx_shift;
                            r_po_err   <= !r_rx_s2 || r_rx_par_err;
                            r_po_flag  <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.tx       = r_tx;
    assign bus.re       = r_re;
    assign bus.tx_ready = r_tx_ready;
    assign bus.po_data  = r_po_data;
    assign bus.po_flag  = r_po_flag;
    assign bus.po_err   = r_po_err;

endmodule
`default_nettype wire
